// File: rtl/uart_pkg.sv
// Shared UART definitions: frame size, receiver FSM states and parity-mode constants.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam bit ParityEven = 1'b0;
  localparam bit ParityOdd  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; expire strobes in the last cycle of a loaded interval.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned W            = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Loading L makes expire fire exactly L edges later.
  assign expire = (count_q == W'(1));

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start/data/parity/stop framing with a valid/ready byte output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          PARITY_ODD   = ParityEven
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned    TW         = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0]  FullBit    = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0]  HalfBit    = TW'(CLKS_PER_BIT / 2);
  localparam bit             ConfirmNow = (CLKS_PER_BIT / 2) == 0;

  uart_rx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_expire;
  logic                 complete;
  logic                 stop_bad;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .W           (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_d    = par_q;
    perr_d   = perr_q;
    tmr_load = 1'b0;
    tmr_val  = FullBit;
    complete = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx) begin
          idx_d    = '0;
          par_d    = 1'b0;
          tmr_load = 1'b1;
          // A half-bit of zero means the detect sample is already the centre sample.
          if (ConfirmNow) begin
            state_d = StData;
          end else begin
            state_d = StStart;
            tmr_val = HalfBit;
          end
        end
      end
      StStart: begin
        if (tmr_expire) begin
          if (!rx) begin
            state_d  = StData;
            tmr_load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tmr_expire) begin
          shift_d  = {rx, shift_q[DATA_BITS-1:1]};
          par_d    = par_q ^ rx;
          idx_d    = idx_q + 3'd1;
          tmr_load = 1'b1;
          if (idx_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (tmr_expire) begin
          perr_d   = par_q ^ rx ^ PARITY_ODD;
          tmr_load = 1'b1;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (tmr_expire) begin
          complete = 1'b1;
          stop_bad = ~rx;
          state_d  = rx ? StIdle : StBreak;
        end
      end
      StBreak: begin
        if (rx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_q;
          parity_err <= perr_q;
          frame_err  <= stop_bad;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: N=1 even/odd parity instances and an N=4 instance.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic reset, rx, rx4, data_ready;

  logic [7:0] d_out, o_out, f_out;
  logic d_valid, d_perr, d_ferr, d_ovr, d_busy;
  logic o_valid, o_perr, o_ferr, o_ovr, o_busy;
  logic f_valid, f_perr, f_ferr, f_ovr, f_busy;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(d_out), .data_valid(d_valid),
    .data_ready(data_ready), .parity_err(d_perr), .frame_err(d_ferr), .overrun(d_ovr),
    .busy(d_busy)
  );

  uart_receiver #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .rx(rx), .data_out(o_out), .data_valid(o_valid),
    .data_ready(data_ready), .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr),
    .busy(o_busy)
  );

  uart_receiver #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut4 (
    .clk(clk), .reset(reset), .rx(rx4), .data_out(f_out), .data_valid(f_valid),
    .data_ready(data_ready), .parity_err(f_perr), .frame_err(f_ferr), .overrun(f_ovr),
    .busy(f_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    sb.push_back(e);
  endtask

  task automatic drive(input bit slow, input logic v);
    if (slow) rx4 = v;
    else rx = v;
    repeat (slow ? 4 : 1) @(negedge clk);
  endtask

  // Start, 8 data LSB first, parity, stop; returns one negedge after the stop-bit edge(s).
  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input bit ready_on_stop, input bit chk_lat, input bit slow);
    drive(slow, 1'b0);
    for (int i = 0; i < 8; i++) drive(slow, b[i]);
    drive(slow, p);
    if (chk_lat) begin
      chk1("pre_stop_valid", d_valid, 1'b0);
      chk1("pre_stop_busy", d_busy, 1'b1);
    end
    if (ready_on_stop) data_ready = 1'b1;
    drive(slow, s);
    data_ready = 1'b0;
  endtask

  task automatic check_output(input bit slow, input int budget);
    int   n;
    logic v;
    exp_t e;
    n = 0;
    v = slow ? f_valid : d_valid;
    while (!v && n < budget) begin
      @(negedge clk);
      n++;
      v = slow ? f_valid : d_valid;
    end
    chk1("valid_seen", v, 1'b1);
    if (sb.size() == 0) begin
      chk1("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk8("data_out", slow ? f_out : d_out, e.data);
      chk1("parity_err", slow ? f_perr : d_perr, e.perr);
      chk1("frame_err", slow ? f_ferr : d_ferr, e.ferr);
    end
  endtask

  task automatic accept();
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk1("accept_valid", d_valid, 1'b0);
    chk1("accept_perr", d_perr, 1'b0);
    chk1("accept_ferr", d_ferr, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk8({tag, "_data"}, d_out, 8'h00);
    chk1({tag, "_valid"}, d_valid, 1'b0);
    chk1({tag, "_perr"}, d_perr, 1'b0);
    chk1({tag, "_ferr"}, d_ferr, 1'b0);
    chk1({tag, "_ovr"}, d_ovr, 1'b0);
    chk1({tag, "_busy"}, d_busy, 1'b0);
  endtask

  logic ovr_seen;

  initial begin
    reset = 1'b1; rx = 1'b1; rx4 = 1'b1; data_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Good frame 0xA5, even parity; the odd-parity instance must flag it.
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    chk1("a5_busy_after", d_busy, 1'b0);
    check_output(1'b0, 0);
    chk1("a5_odd_perr", o_perr, 1'b1);
    accept();

    // 0x01 with parity bit 0: even-mode error, odd-mode clean.
    push_exp(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_output(1'b0, 4);
    chk8("01_odd_data", o_out, 8'h01);
    chk1("01_odd_perr", o_perr, 1'b0);
    accept();

    // Stop bit low followed by a 20-cycle break.
    push_exp(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output(1'b0, 4);
    ovr_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("break_busy", d_busy, 1'b1);
      ovr_seen = ovr_seen | d_ovr;
    end
    chk1("break_no_overrun", ovr_seen, 1'b0);
    chk8("break_data_held", d_out, 8'h3C);
    rx = 1'b1;
    @(negedge clk);
    chk1("break_exit_busy", d_busy, 1'b0);
    accept();

    // Overrun: 0x22 completes while 0x11 is still held.
    push_exp(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output(1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("ovr_pulse", d_ovr, 1'b1);
    chk8("ovr_data_held", d_out, 8'h11);
    @(negedge clk);
    chk1("ovr_pulse_end", d_ovr, 1'b0);
    accept();

    // Same pair, but the held byte is accepted on the completion edge.
    push_exp(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output(1'b0, 0);
    push_exp(8'h22, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("no_ovr", d_ovr, 1'b0);
    check_output(1'b0, 0);
    accept();

    // Glitch rejection at N=4, then a clean frame on the same instance.
    rx4 = 1'b0;
    @(negedge clk);
    rx4 = 1'b1;
    chk1("glitch_busy", f_busy, 1'b1);
    repeat (3) @(negedge clk);
    chk1("glitch_idle", f_busy, 1'b0);
    chk1("glitch_no_valid", f_valid, 1'b0);
    push_exp(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output(1'b1, 8);

    // Reset mid-frame with a byte pending, then a clean 0x5A.
    push_exp(8'h77, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output(1'b0, 0);
    rx = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      @(negedge clk);
    end
    rx = 1'b1;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_output(1'b0, 4);
    accept();

    chk8("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
